// File: rtl/ece571_cpu_pkg.sv
// ece571 CPU shared types: ALU opcodes, the issue-queue instruction record and
// the issue-controller state encoding.
// Ports: none (package). Imported by the issue controller and its instruction FIFO.
package ece571_cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5
   } opcode_t;

   // MSB-first layout matches the in_instr bus: {opcode, rd, rs1, rs2}
   typedef struct packed {
      opcode_t    opcode;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
   } issue_instr_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } issue_state_t;

   localparam int ISSUE_DEPTH   = 4;
   localparam int ISSUE_INSTR_W = $bits(issue_instr_t);

   // True when the instruction sources the given register on either port
   function automatic logic reads_reg(input issue_instr_t instr, input logic [3:0] addr);
      return (instr.rs1 == addr) || (instr.rs2 == addr);
   endfunction

endpackage

// File: rtl/ece571_instr_fifo.sv
// Generic synchronous FIFO holding queued instructions; head word is visible
// combinationally on dout. Latency: a push is readable on dout the cycle after.
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk, reset (async, active-high), push/din, pop/dout, full, empty, count.
module ece571_instr_fifo
   import ece571_cpu_pkg::*;
#(
   parameter int WIDTH = ISSUE_INSTR_W,
   parameter int DEPTH = ISSUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only pointers and occupancy define validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so pointer wrap is plain binary rollover
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ece571_issue_ctrl.sv
// In-order issue controller: queues ALU instructions, drives regfile reads and
// ALU operands for the head (EX), then registers the result for writeback (WB).
// Latency: offer-to-wb_we 2 cycles on an empty queue, 1 instr/cycle without hazards.
// Backpressure: in_ready drops only when the queue holds DEPTH entries; a RAW hit
// against WB costs one bubble unless ECE571_ISSUE_FORWARD_EN is defined, which adds
// WB->EX operand forwarding and removes the stall entirely.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_instr instruction
// handshake; rf_raddr1/2 + rf_rdata1/2 regfile read; alu_a/alu_b/alu_op/alu_result
// ALU hookup; wb_we/wb_addr/wb_data regfile write; busy; stall_cnt.
module ece571_issue_ctrl
   import ece571_cpu_pkg::*;
#(
   parameter int N     = 32,
   parameter int OP_W  = 4,
   parameter int DEPTH = ISSUE_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W+11:0]  in_instr,
   output logic [3:0]        rf_raddr1,
   output logic [3:0]        rf_raddr2,
   input  logic [N-1:0]      rf_rdata1,
   input  logic [N-1:0]      rf_rdata2,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [N-1:0]      alu_result,
   output logic              wb_we,
   output logic [3:0]        wb_addr,
   output logic [N-1:0]      wb_data,
   output logic              busy,
   output logic [15:0]       stall_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [OP_W+11:0] head_bits;
   issue_instr_t     head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             pop;
   logic             hazard;
   logic             has_head;
   logic [N-1:0]     opnd_a;
   logic [N-1:0]     opnd_b;
   issue_state_t     state;

   ece571_instr_fifo #(
      .WIDTH (OP_W + 12),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid),
      .din   (in_instr),
      .pop   (pop),
      .dout  (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head     = issue_instr_t'(head_bits);
   assign in_ready = !fifo_full;
   assign busy     = !fifo_empty || wb_we;

`ifdef ECE571_ISSUE_FORWARD_EN
   // The WB value is not in the regfile until the end of WB, so take it directly
   assign hazard = 1'b0;
   assign opnd_a = (wb_we && (wb_addr == head.rs1)) ? wb_data : rf_rdata1;
   assign opnd_b = (wb_we && (wb_addr == head.rs2)) ? wb_data : rf_rdata2;
`else
   // The stall cycle drops wb_we, so the hazard clears by itself the next cycle
   assign hazard = wb_we && reads_reg(head, wb_addr);
   assign opnd_a = rf_rdata1;
   assign opnd_b = rf_rdata2;
`endif

   // EX has no memory of its own: the mode follows occupancy and the WB register
   always_comb begin
      state = EMPTY;
      if (fifo_count != '0) begin
         state = hazard ? STALL : ISSUE;
      end
   end

   assign pop      = (state == ISSUE);
   assign has_head = (state != EMPTY);

   // Stale FIFO storage must not leak onto the datapath when nothing is queued
   assign rf_raddr1 = has_head ? head.rs1 : '0;
   assign rf_raddr2 = has_head ? head.rs2 : '0;
   assign alu_op    = has_head ? OP_W'(head.opcode) : '0;
   assign alu_a     = has_head ? opnd_a : '0;
   assign alu_b     = has_head ? opnd_b : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_we     <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
         stall_cnt <= '0;
      end else begin
         case (state)
            ISSUE: begin
               wb_we   <= 1'b1;
               wb_addr <= head.rd;
               wb_data <= alu_result;
            end
            STALL: begin
               wb_we <= 1'b0;
               if (stall_cnt != 16'hFFFF) begin
                  stall_cnt <= stall_cnt + 16'd1;
               end
            end
            default: begin
               wb_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ece571_issue_ctrl.sv
// Testbench for ece571_issue_ctrl: models the regfile and ALU around the DUT and
// checks every writeback against an in-order architectural model of the program.
module tb_ece571_issue_ctrl;
   import ece571_cpu_pkg::*;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_instr;
   logic [3:0]    rf_raddr1, rf_raddr2;
   logic [N-1:0]  rf_rdata1, rf_rdata2;
   logic [N-1:0]  alu_a, alu_b, alu_result;
   logic [3:0]    alu_op;
   logic          wb_we;
   logic [3:0]    wb_addr;
   logic [N-1:0]  wb_data;
   logic          busy;
   logic [15:0]   stall_cnt;

   ece571_issue_ctrl #(.N(N), .OP_W(4), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rf_raddr1  (rf_raddr1),
      .rf_raddr2  (rf_raddr2),
      .rf_rdata1  (rf_rdata1),
      .rf_rdata2  (rf_rdata2),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] alu_model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         default: return '0;
      endcase
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   // Environment: 16x32 regfile with combinational read, ALU, and a preload port
   logic [N-1:0] rf [16];
   logic         pl_en;
   logic [3:0]   pl_a1, pl_a2;
   logic [N-1:0] pl_d1, pl_d2;

   assign rf_rdata1  = rf[rf_raddr1];
   assign rf_rdata2  = rf[rf_raddr2];
   assign alu_result = alu_model(alu_op, alu_a, alu_b);

   always @(posedge clk) begin
      if (pl_en) begin
         rf[pl_a1] <= pl_d1;
         rf[pl_a2] <= pl_d2;
      end else if (wb_we) begin
         rf[wb_addr] <= wb_data;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: architectural register state advanced in program order
   typedef struct packed {
      logic [3:0]   rd;
      logic [N-1:0] data;
   } wb_exp_t;

   wb_exp_t      exp_q[$];
   logic [N-1:0] arch [16];
   int           acc_cnt = 0;
   int           wr_cnt = 0;
   int           run = 0;
   int           max_run = 0;
   bit           saw_block = 1'b0;

   initial begin
      wb_exp_t      e;
      logic [15:0]  ins;
      logic [N-1:0] r;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            acc_cnt = 0;
            wr_cnt  = 0;
            run     = 0;
         end else begin
            if (wb_we) begin
               wr_cnt++;
               run++;
               if (run > max_run) max_run = run;
               if (exp_q.size() == 0) begin
                  check("unexpected_wb", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_wb_addr", wb_addr, e.rd);
                  check("sb_wb_data", wb_data, e.data);
               end
            end else begin
               run = 0;
            end
            // queue occupancy = accepted so far minus issued so far
            check("in_ready_occ", in_ready, (acc_cnt - wr_cnt) < 4);
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (exp_q.size() == 0 && !wb_we) begin
               for (int i = 0; i < 16; i++) arch[i] = rf[i];
            end
            if (in_valid && in_ready) begin
               ins = in_instr;
               r = alu_model(ins[15:12], arch[ins[7:4]], arch[ins[3:0]]);
               arch[ins[11:8]] = r;
               exp_q.push_back('{rd: ins[11:8], data: r});
               acc_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      pl_en    = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic preload(input logic [3:0] a1, input logic [N-1:0] d1, input logic [3:0] a2, input logic [N-1:0] d2);
      pl_a1 = a1; pl_d1 = d1; pl_a2 = a2; pl_d2 = d2;
      pl_en = 1'b1;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic send(input logic [15:0] ins);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_instr = ins;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready stuck low for %0d cycles", w);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((busy || exp_q.size() != 0) && w < 300) begin
         tick();
         w++;
      end
      if (w >= 300) begin
         tests++; fails++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, exp_q.size());
      end
      tick();
   endtask

   typedef struct {
      logic [3:0]   op, rd, rs1, rs2;
      logic [N-1:0] va, vb, res;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{OP_ADD, 4'd3,  4'd1,  4'd2,  32'd5,         32'd7,         32'd12};
      tbl[1] = '{OP_SUB, 4'd8,  4'd9,  4'd10, 32'd10,        32'd3,         32'd7};
      tbl[2] = '{OP_AND, 4'd0,  4'd11, 4'd12, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      tbl[3] = '{OP_OR,  4'd15, 4'd13, 4'd14, 32'h0000_00F0, 32'h0F00_0000, 32'h0F00_00F0};
      tbl[4] = '{OP_XOR, 4'd2,  4'd2,  4'd2,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0};
      tbl[5] = '{OP_SUB, 4'd1,  4'd1,  4'd2,  32'd0,         32'd1,         32'hFFFF_FFFF};
      tbl[6] = '{OP_ADD, 4'd9,  4'd4,  4'd5,  32'hFFFF_FFFF, 32'd1,         32'd0};

      reset    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      pl_en    = 1'b0;
      pl_a1 = '0; pl_a2 = '0; pl_d1 = '0; pl_d2 = '0;
      #1 reset = 1'b1;
      #1;
      check("rst_wb_we",     wb_we, 1'b0);
      check("rst_wb_addr",   wb_addr, 4'd0);
      check("rst_wb_data",   wb_data, 32'd0);
      check("rst_in_ready",  in_ready, 1'b1);
      check("rst_busy",      busy, 1'b0);
      check("rst_stall_cnt", stall_cnt, 16'd0);
      check("rst_alu_op",    alu_op, 4'd0);
      check("rst_alu_a",     alu_a, 32'd0);
      check("rst_raddr1",    rf_raddr1, 4'd0);
      do_reset();

      // Single instructions into an empty queue: EX presentation and one WB cycle
      for (int i = 0; i < 7; i++) begin
         preload(tbl[i].rs1, tbl[i].va, tbl[i].rs2, tbl[i].vb);
         send(mk(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2));
         check("ex_wb_we",  wb_we, 1'b0);
         check("ex_raddr1", rf_raddr1, tbl[i].rs1);
         check("ex_raddr2", rf_raddr2, tbl[i].rs2);
         check("ex_alu_op", alu_op, tbl[i].op);
         check("ex_alu_a",  alu_a, tbl[i].va);
         check("ex_alu_b",  alu_b, tbl[i].vb);
         tick();
         check("wb_we",     wb_we, 1'b1);
         check("wb_addr",   wb_addr, tbl[i].rd);
         check("wb_data",   wb_data, tbl[i].res);
         tick();
         check("wb_once",   wb_we, 1'b0);
         check("wb_idle",   busy, 1'b0);
         wait_idle();
      end
      check("table_stall_cnt", stall_cnt, 16'd0);

      // Four independent instructions back to back
      do_reset();
      preload(4'd1, 32'd5, 4'd2, 32'd7);
      max_run = 0;
      send(mk(OP_ADD, 4'd4, 4'd1, 4'd2));
      send(mk(OP_SUB, 4'd5, 4'd1, 4'd2));
      send(mk(OP_AND, 4'd6, 4'd1, 4'd2));
      send(mk(OP_OR,  4'd7, 4'd1, 4'd2));
      wait_idle();
      check("b2b_run",    max_run, 4);
      check("b2b_writes", wr_cnt, 4);
      check("b2b_stall",  stall_cnt, 16'd0);
      check("b2b_r4", rf[4], 32'd12);
      check("b2b_r5", rf[5], 32'hFFFF_FFFE);
      check("b2b_r6", rf[6], 32'd5);
      check("b2b_r7", rf[7], 32'd7);

      // Read-after-write against the writeback stage
      do_reset();
      preload(4'd1, 32'd5, 4'd2, 32'd7);
      max_run = 0;
      send(mk(OP_ADD, 4'd3, 4'd1, 4'd2));
      send(mk(OP_ADD, 4'd4, 4'd3, 4'd1));
      wait_idle();
      check("raw_r3", rf[3], 32'd12);
      check("raw_r4", rf[4], 32'd17);
      check("raw_writes", wr_cnt, 2);
`ifdef ECE571_ISSUE_FORWARD_EN
      check("raw_run",   max_run, 2);
      check("raw_stall", stall_cnt, 16'd0);
`else
      check("raw_run",   max_run, 1);
      check("raw_stall", stall_cnt, 16'd1);
`endif

      // Dependent chain with in_valid held high: fills the queue and wraps pointers
      do_reset();
      preload(4'd5, 32'd0, 4'd1, 32'd3);
      saw_block = 1'b0;
      for (int i = 0; i < 10; i++) send(mk(OP_ADD, 4'd5, 4'd5, 4'd1));
      wait_idle();
      check("chain_r5",     rf[5], 32'd30);
      check("chain_writes", wr_cnt, 10);
`ifdef ECE571_ISSUE_FORWARD_EN
      check("chain_block", saw_block, 1'b0);
      check("chain_stall", stall_cnt, 16'd0);
`else
      check("chain_block", saw_block, 1'b1);
      check("chain_stall", stall_cnt, 16'd9);
`endif

      // Random program with idle gaps
      do_reset();
      for (int r = 0; r < 8; r++) preload(4'(2*r), $urandom(), 4'(2*r+1), $urandom());
      for (int i = 0; i < 300; i++) begin
         send(mk(4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
      wait_idle();
      check("rand_writes", wr_cnt, 300);
`ifdef ECE571_ISSUE_FORWARD_EN
      check("rand_stall", stall_cnt, 16'd0);
`endif

      // Reset in the middle of a stalled chain
      do_reset();
      preload(4'd6, 32'd1, 4'd1, 32'd2);
      for (int i = 0; i < 5; i++) send(mk(OP_ADD, 4'd6, 4'd6, 4'd1));
      begin
         int w;
         w = 0;
         while (!wb_we && w < 20) begin
            tick();
            w++;
         end
         check("mid_wb_seen", wb_we, 1'b1);
      end
      reset = 1'b1;
      #1;
      check("mid_rst_wb_we",    wb_we, 1'b0);
      check("mid_rst_busy",     busy, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_busy",     busy, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_stall",    stall_cnt, 16'd0);
      check("post_rst_alu_op",   alu_op, 4'd0);
      repeat (10) tick();
      check("post_rst_writes", wr_cnt, 0);
      check("post_rst_wb_we",  wb_we, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
